// File: rtl/spi_sck_burst_gen.sv
// SPI SCK burst generator: emits nbits SCK cycles in any CPOL/CPHA mode, with
// edge-aligned single-cycle sample/shift strobes and a start/busy/done/abort handshake.
module spi_sck_burst_gen #(
   parameter int DIV_WIDTH = 16,
   parameter int CNT_WIDTH = 6
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic [DIV_WIDTH-1:0] divider,
   input  logic                 cpol,
   input  logic                 cpha,
   input  logic [CNT_WIDTH-1:0] nbits,
   input  logic                 start,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic                 SCK,
   output logic                 sample_strobe,
   output logic                 shift_strobe
);

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH:0]   EDGE_ONE = {{CNT_WIDTH{1'b0}}, 1'b1};

   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH:0]   edge_q, edge_d;
   logic [CNT_WIDTH:0]   edge_n;
   logic [DIV_WIDTH-1:0] div_l_q, div_l_d;
   logic [CNT_WIDTH-1:0] nbits_l_q, nbits_l_d;
   logic                 cpol_l_q, cpol_l_d;
   logic                 cpha_l_q, cpha_l_d;
   logic                 sck_q, sck_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 sample_q, sample_d;
   logic                 shift_q, shift_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      edge_d    = edge_q;
      div_l_d   = div_l_q;
      nbits_l_d = nbits_l_q;
      cpol_l_d  = cpol_l_q;
      cpha_l_d  = cpha_l_q;
      sck_d     = sck_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      sample_d  = 1'b0;
      shift_d   = 1'b0;
      edge_n    = edge_q + EDGE_ONE;

      case (state_q)
         IDLE: begin
            sck_d  = cpol;
            busy_d = 1'b0;
            // abort takes priority over a simultaneous start
            if (start && !abort) begin
               div_l_d   = divider;
               nbits_l_d = nbits;
               cpol_l_d  = cpol;
               cpha_l_d  = cpha;
               cnt_d     = '0;
               edge_d    = '0;
               if (nbits != '0) begin
                  state_d = RUN;
                  busy_d  = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               sck_d   = cpol_l_q;
               cnt_d   = '0;
               edge_d  = '0;
            end else if (cnt_q == div_l_q) begin
               cnt_d  = '0;
               edge_d = edge_n;
               sck_d  = ~sck_q;
               // odd edge count = leading edge; the last trailing edge never shifts
               if (edge_n[0]) begin
                  sample_d = ~cpha_l_q;
                  shift_d  = cpha_l_q;
               end else begin
                  sample_d = cpha_l_q;
                  shift_d  = ~cpha_l_q && (edge_n != {nbits_l_q, 1'b0});
               end
               if (edge_n == {nbits_l_q, 1'b0}) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  edge_d  = '0;
               end else begin
                  state_d = RUN;
               end
            end else begin
               cnt_d = cnt_q + DIV_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            sck_d   = cpol;
            cnt_d   = '0;
            edge_d  = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         edge_q    <= '0;
         div_l_q   <= '0;
         nbits_l_q <= '0;
         cpol_l_q  <= 1'b0;
         cpha_l_q  <= 1'b0;
         sck_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sample_q  <= 1'b0;
         shift_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         edge_q    <= edge_d;
         div_l_q   <= div_l_d;
         nbits_l_q <= nbits_l_d;
         cpol_l_q  <= cpol_l_d;
         cpha_l_q  <= cpha_l_d;
         sck_q     <= sck_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sample_q  <= sample_d;
         shift_q   <= shift_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign SCK           = sck_q;
   assign sample_strobe = sample_q;
   assign shift_strobe  = shift_q;

endmodule

// File: tb/tb_spi_sck_burst_gen.sv
// Directed table-driven bench for spi_sck_burst_gen: one vector per CLK cycle,
// plus hand-written sequences for mid-burst reset and a wider divider.
module tb_spi_sck_burst_gen;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [15:0] divider;
   logic        cpol, cpha;
   logic [5:0]  nbits;
   logic        start, abort;
   logic        busy, done, SCK, sample_strobe, shift_strobe;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        start;
      logic        abort;
      logic        cpol;
      logic        cpha;
      logic [15:0] div;
      logic [5:0]  nbits;
      logic [4:0]  exp;   // {busy, done, SCK, sample, shift}
   } vec_t;

   vec_t vecs[$];

   spi_sck_burst_gen #(.DIV_WIDTH(16), .CNT_WIDTH(6)) dut (
      .CLK(CLK), .nRST(nRST), .divider(divider), .cpol(cpol), .cpha(cpha),
      .nbits(nbits), .start(start), .abort(abort), .busy(busy), .done(done),
      .SCK(SCK), .sample_strobe(sample_strobe), .shift_strobe(shift_strobe)
   );

   always #5 CLK = ~CLK;

   function automatic logic [4:0] outs();
      return {busy, done, SCK, sample_strobe, shift_strobe};
   endfunction

   task automatic add(input logic s, input logic a, input logic pol, input logic pha,
                      input logic [15:0] d, input logic [5:0] n, input logic [4:0] e);
      vec_t v;
      v.start = s; v.abort = a; v.cpol = pol; v.cpha = pha;
      v.div = d; v.nbits = n; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   initial begin
      int  cyc;
      logic seen;

      nRST = 1'b0; divider = '0; cpol = 1'b0; cpha = 1'b0;
      nbits = '0; start = 1'b0; abort = 1'b0;
      #12;
      check("reset_outputs", {27'd0, outs()}, 32'd0);

      // mode 0: div=1 nbits=2
      add(1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 6'd2, 5'b10000);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 6'd2, 5'b10000);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 6'd2, 5'b10110);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 6'd2, 5'b10100);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 6'd2, 5'b10001);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 6'd2, 5'b10000);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 6'd2, 5'b10110);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 6'd2, 5'b10100);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 6'd2, 5'b01000);
      // idle SCK follows cpol with one cycle lag
      add(1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 6'd3, 5'b00100);
      // mode 3: div=0 nbits=3
      add(1'b1, 1'b0, 1'b1, 1'b1, 16'd0, 6'd3, 5'b10100);
      add(1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 6'd3, 5'b10001);
      add(1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 6'd3, 5'b10110);
      add(1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 6'd3, 5'b10001);
      add(1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 6'd3, 5'b10110);
      add(1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 6'd3, 5'b10001);
      add(1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 6'd3, 5'b01110);
      // back-to-back start in the done cycle
      add(1'b1, 1'b0, 1'b1, 1'b1, 16'd0, 6'd3, 5'b10100);
      // config changes and start while busy are ignored
      add(1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 6'd1, 5'b10001);
      add(1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 6'd1, 5'b10110);
      add(1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 6'd1, 5'b10001);
      add(1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 6'd1, 5'b10110);
      add(1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 6'd1, 5'b10001);
      add(1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 6'd1, 5'b01110);
      // nbits=0: done pulse only
      add(1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 6'd0, 5'b00100);
      add(1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 6'd0, 5'b01100);
      add(1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 6'd0, 5'b00100);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 6'd4, 5'b00000);
      // abort after the 3rd of 8 edges
      add(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 6'd4, 5'b10000);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 6'd4, 5'b10110);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 6'd4, 5'b10001);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 6'd4, 5'b10110);
      add(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 6'd4, 5'b00000);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 6'd4, 5'b00000);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 6'd4, 5'b00000);
      // abort and start together in IDLE: start dropped
      add(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 6'd2, 5'b00000);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 6'd2, 5'b00000);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 6'd2, 5'b00000);

      @(negedge CLK);
      nRST = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge CLK);
         start = vecs[i].start; abort = vecs[i].abort; cpol = vecs[i].cpol;
         cpha = vecs[i].cpha; divider = vecs[i].div; nbits = vecs[i].nbits;
         @(posedge CLK);
         #1;
         check($sformatf("vec%0d", i), {27'd0, outs()}, {27'd0, vecs[i].exp});
      end

      // divider=3, mode 1, single bit: edges 4 and 8 cycles after acceptance
      @(negedge CLK);
      start = 1'b1; abort = 1'b0; cpol = 1'b0; cpha = 1'b1; divider = 16'd3; nbits = 6'd1;
      @(posedge CLK);
      @(negedge CLK);
      start = 1'b0;
      cyc = 0;
      while (cyc < 50) begin
         @(posedge CLK); #1; cyc++;
         if (shift_strobe) break;
      end
      check("div3_first_edge_cycles", cyc, 32'd4);
      check("div3_first_edge_sck", {31'd0, SCK}, 32'd1);
      cyc = 0;
      while (cyc < 50) begin
         @(posedge CLK); #1; cyc++;
         if (sample_strobe) break;
      end
      check("div3_second_edge_cycles", cyc, 32'd4);
      check("div3_done_with_last_edge", {30'd0, busy, done}, 32'd1);

      // async reset mid-burst
      @(negedge CLK);
      start = 1'b1; cpol = 1'b1; cpha = 1'b0; divider = 16'd2; nbits = 6'd3;
      @(negedge CLK);
      start = 1'b0;
      repeat (4) @(posedge CLK);
      #2;
      nRST = 1'b0;
      #1;
      check("mid_burst_reset", {27'd0, outs()}, 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(posedge CLK); #1;
         if (done || busy || sample_strobe || shift_strobe) seen = 1'b1;
      end
      check("no_activity_after_reset", {31'd0, seen}, 32'd0);
      check("idle_sck_after_reset", {31'd0, SCK}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_sck_burst_gen.md
Name: spi_sck_burst_gen

Overview:
- Parametrised successor to the free-running SPI clock divider.
- Generates a bounded burst of SCK cycles, one per bit. Supports all four CPOL/CPHA modes, a start/busy/done handshake and abort.
- Emits single-cycle sample and shift strobes aligned to SCK edges, so the SPI master shift register needs no edge detection.
- Sits between the SPI master control FSM and the SCK pad.

Parameters:
- DIV_WIDTH, 16: width of the half-period divider; one SCK half-period = divider+1 CLK cycles.
- CNT_WIDTH, 6: width of the bit-count input; a burst is at most 2^CNT_WIDTH-1 bits.

Ports:
- CLK  input  1  system clock.
- nRST  input  1  asynchronous active-low reset.
- divider  input  DIV_WIDTH  half-period minus one; latched at start.
- cpol  input  1  SCK idle level; latched at start (live while idle).
- cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at start.
- nbits  input  CNT_WIDTH  number of SCK cycles in the burst; latched at start.
- start  input  1  burst request; honoured only when busy=0.
- abort  input  1  synchronous burst cancel.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse on normal burst completion.
- SCK  output  1  serial clock, registered.
- sample_strobe  output  1  one-cycle pulse, coincident with a sampling SCK edge.
- shift_strobe  output  1  one-cycle pulse, coincident with a shifting SCK edge.

Behaviour:
- Reset (nRST=0, async): state IDLE, SCK=0, busy=0, done=0, both strobes 0, all counters 0.
- States: IDLE, RUN. done is a registered pulse, not a state.
- IDLE:
  - SCK follows cpol, registered (one-cycle lag).
  - Strobes are 0.
  - start=1 at edge t latches divider/cpol/cpha/nbits, clears the half-period counter and edge counter, and sets busy=1 from edge t.
- RUN:
  - The half-period counter (DIV_WIDTH bits) increments each cycle.
  - When count==divider_l: count wraps to 0, SCK toggles, edge counter increments.
  - The k-th SCK edge is registered at edge t+k*(divider_l+1), for k=1..2*nbits_l.
  - Odd k is the leading edge; even k is the trailing edge.
  - The edge counter is CNT_WIDTH+1 bits wide. No overflow is possible.
- Strobes are registered with the SCK toggle, so they are high in the first cycle SCK shows its new level:
  - cpha=0: sample_strobe on every leading edge (nbits pulses). shift_strobe on trailing edges 1..nbits-1 only (nbits-1 pulses); the final trailing edge has no shift. The caller presents bit 0 before start.
  - cpha=1: shift_strobe on every leading edge. sample_strobe on every trailing edge (nbits pulses each).
- Completion: at the edge registering the final (2*nbits_l-th) toggle, busy<=0 and done<=1. done clears on the next edge. SCK ends at cpol_l.
- Back-to-back bursts: start in the done cycle (busy=0) is accepted. busy stays 0 for exactly that one cycle.
- nbits=0 at start: no toggles and no strobes. busy is never asserted; done pulses in the cycle after start is sampled.
- divider=0: SCK toggles every CLK cycle; SCK period is 2 CLK cycles.
- start while busy=1: ignored.
- Input changes while busy: ignored, because all configuration is latched.
- abort=1 while busy: at the next edge, state->IDLE, busy=0, SCK<=cpol_l, counters cleared. No strobe and no done pulse.
- abort in IDLE: no effect.
- abort and start in the same IDLE cycle: abort wins, and start is dropped.
- Async reset mid-burst: immediate return to reset values. No done pulse.

Test Plan:
- Mode 0 (divider=1, nbits=2, cpol=0, cpha=0), start at edge 0 -> busy 1 from edge 0; SCK rises at edges 2 and 6, falls at 4 and 8; sample_strobe at 2 and 6; shift_strobe at 4 only; done pulse and busy 0 at edge 8.
- Mode 3 (divider=0, nbits=3, cpol=1, cpha=1) -> SCK falls at edges 1/3/5, rises at 2/4/6; shift_strobe at 1/3/5; sample_strobe at 2/4/6; done at 6; SCK=1 afterwards.
- Back-to-back: second start in the done cycle -> busy low exactly 1 cycle; second burst's first edge at divider+1 cycles after acceptance.
- abort asserted mid-burst after edge 3 of 8 -> next cycle busy=0, SCK=cpol, no further strobes, done never pulses.
- nbits=0 start -> busy stays 0, SCK constant, done pulse next cycle.
- Changing divider/cpol mid-burst, start while busy, and nRST low mid-burst -> burst timing unchanged and start ignored; on reset, SCK/busy/done=0 immediately.
